// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: turns the async FIFO pop interface into a valid/ready stream via a prefetching skid buffer.
// Define RDA_B2B_EN for back-to-back pops (only when the FIFO empty flag reflects a pop on the next cycle).
module fifo_rd_stream_adapter #(
   parameter int WIDTH     = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic                           rd_clk,
   input  logic                           rrst_n,
   input  logic                           enable,
   input  logic                           fifo_empty,
   output logic                           fifo_rd_en,
   input  logic [WIDTH-1:0]               fifo_rd_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [WIDTH-1:0]               m_data,
   output logic [$clog2(BUF_DEPTH+1)-1:0] buf_cnt,
   output logic                           idle
);
   localparam int CW = $clog2(BUF_DEPTH+1);
   localparam int OW = CW + 1;
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   logic [WIDTH-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]    head, tail, head_nxt, tail_nxt;
   logic             infl, holdoff, pop;
   logic [OW-1:0]    occ;
   assign pop      = m_valid & m_ready;
   // occupancy once this cycle's write and pop retire; a new pop must still fit after that
   assign occ      = {1'b0, buf_cnt} + OW'(infl) - OW'(pop);
   assign fifo_rd_en = rrst_n & enable & !fifo_empty & !holdoff & (occ < OW'(BUF_DEPTH));
   assign m_valid  = buf_cnt != '0;
   assign m_data   = mem[head];
   assign idle     = (buf_cnt == '0) & !infl;
   assign head_nxt = (head == PW'(BUF_DEPTH-1)) ? '0 : head + PW'(1);
   assign tail_nxt = (tail == PW'(BUF_DEPTH-1)) ? '0 : tail + PW'(1);
   always_ff @(posedge rd_clk or negedge rrst_n) begin
      if (!rrst_n) begin
         infl    <= 1'b0;
         head    <= '0;
         tail    <= '0;
         buf_cnt <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      end else begin
         infl    <= fifo_rd_en;
         buf_cnt <= CW'(occ);
         if (infl) begin
            mem[tail] <= fifo_rd_data;
            tail      <= tail_nxt;
         end
         if (pop) head <= head_nxt;
      end
   end
`ifdef RDA_B2B_EN
   assign holdoff = 1'b0;
`else
   // registered FIFO empty flag lags a pop by a cycle, so never pop on consecutive cycles
   always_ff @(posedge rd_clk or negedge rrst_n) begin
      if (!rrst_n) holdoff <= 1'b0;
      else         holdoff <= fifo_rd_en;
   end
`endif
   a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rrst_n)
      !(infl && !pop && buf_cnt == CW'(BUF_DEPTH)));
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed stimulus against a queue-based FIFO model, scoreboard-checked stream output.
module tb_fifo_rd_stream_adapter;
   logic       rd_clk = 1'b0, rrst_n = 1'b0, enable = 1'b0, fifo_empty = 1'b1, m_ready = 1'b0;
   logic       fifo_rd_en, m_valid, idle;
   logic [7:0] fifo_rd_data = '0, m_data;
   logic [1:0] buf_cnt;
   int         n_cmp = 0, n_bad = 0, cyc = 0, npop = 0, last_pop = 0, nrecv = 0;
   int         first_pop, np0, r0, n;
   logic [7:0] fq[$], expq[$];
   logic       held = 1'b0;
   logic [7:0] held_data = '0;
`ifndef RDA_B2B_EN
   logic       prev_en = 1'b0;
`endif

   fifo_rd_stream_adapter #(.WIDTH(8), .BUF_DEPTH(2)) dut (
      .rd_clk(rd_clk), .rrst_n(rrst_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .buf_cnt(buf_cnt), .idle(idle));

   always #5 rd_clk = ~rd_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      expq.push_back(w);
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((expq.size() != 0 || fq.size() != 0 || !idle) && k < 200) begin
         tick();
         k++;
      end
      chk({name, "_left"}, 32'(expq.size()), 0);
      chk({name, "_idle"}, 32'(idle), 1);
   endtask

   // FIFO model: registered read data, empty flag reflects pops and pushes on the next edge
   always @(posedge rd_clk) begin
      if (fifo_rd_en) begin
         chk("pop_nonempty", 32'(fq.size() != 0), 1);
`ifndef RDA_B2B_EN
         chk("pop_spacing", 32'(prev_en), 0);
`endif
         last_pop = cyc;
         npop++;
         if (fq.size() != 0) fifo_rd_data <= fq.pop_front();
      end
      fifo_empty <= (fq.size() == 0);
`ifndef RDA_B2B_EN
      prev_en = fifo_rd_en;
`endif
      cyc++;
   end

   // stream monitor: a transfer is committed at the next posedge, m_ready only changes just after posedges
   always @(negedge rd_clk) begin
      if (rrst_n) begin
         if (held && m_valid) chk("hold_stable", 32'(m_data), 32'(held_data));
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_word: got %0h expected none", m_data);
            end else chk("stream_data", 32'(m_data), 32'(expq.pop_front()));
            nrecv++;
         end
         held      = m_valid && !m_ready;
         held_data = m_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      // 1. reset values, latency, small burst
      #2;
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_data", 32'(m_data), 0);
      chk("rst_cnt", 32'(buf_cnt), 0);
      chk("rst_idle", 32'(idle), 1);
      tick(); tick();
      rrst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
      push(8'hA1); push(8'hA2); push(8'hA3);
      tick();
      chk("lat_rd_en_N", 32'(fifo_rd_en), 1);
      chk("lat_valid_N", 32'(m_valid), 0);
      tick();
      chk("lat_valid_N1", 32'(m_valid), 0);
      tick();
      chk("lat_valid_N2", 32'(m_valid), 1);
      chk("lat_data_N2", 32'(m_data), 32'h A1);
      drain("t1");
      // 2. backpressure
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
      repeat (10) tick();
      chk("bp_cnt", 32'(buf_cnt), 2);
      chk("bp_rd_en", 32'(fifo_rd_en), 0);
      chk("bp_data", 32'(m_data), 32'h B0);
      m_ready = 1'b1;
      drain("t2");
      // 3. throughput
      for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
      np0 = npop;
      tick();
      chk("tp_first_pop", 32'(fifo_rd_en), 1);
      first_pop = cyc;
      drain("t3");
      chk("tp_pops", 32'(npop - np0), 16);
`ifdef RDA_B2B_EN
      chk("tp_span", 32'(last_pop - first_pop), 15);
`else
      chk("tp_span", 32'(last_pop - first_pop), 30);
`endif
      // 4. empty rises as the last pop issues
      np0 = npop;
      push(8'h5A); push(8'h5B);
      drain("t4");
      repeat (5) tick();
      chk("bd_pops", 32'(npop - np0), 2);
      chk("bd_rd_en", 32'(fifo_rd_en), 0);
      chk("bd_valid", 32'(m_valid), 0);
      // 5. pause with a pop in flight
      enable = 1'b0;
      for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
      tick();
      chk("pa_off_rd_en", 32'(fifo_rd_en), 0);
      enable = 1'b1;
      #1;
      chk("pa_on_rd_en", 32'(fifo_rd_en), 1);
      np0 = npop;
      r0  = nrecv;
      tick();
      enable = 1'b0;
      repeat (5) tick();
      chk("pa_pops", 32'(npop - np0), 1);
      chk("pa_recv", 32'(nrecv - r0), 1);
      chk("pa_rd_en", 32'(fifo_rd_en), 0);
      enable = 1'b1;
      drain("t5");
      chk("pa_all_pops", 32'(npop - np0), 4);
      // 6. async reset mid-stream
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
      n = 0;
      while (buf_cnt != 2'd2 && n < 20) begin
         tick();
         n++;
      end
      chk("mr_cnt_before", 32'(buf_cnt), 2);
      #2;
      rrst_n = 1'b0;
      #1;
      chk("mr_valid", 32'(m_valid), 0);
      chk("mr_cnt", 32'(buf_cnt), 0);
      chk("mr_idle", 32'(idle), 1);
      chk("mr_data", 32'(m_data), 0);
      fq.delete();
      expq.delete();
      tick(); tick();
      rrst_n = 1'b1;
      m_ready = 1'b1;
      r0 = nrecv;
      repeat (6) begin
         tick();
         chk("mr_no_stale", 32'(m_valid), 0);
      end
      push(8'hE5);
      drain("t6");
      chk("mr_recv", 32'(nrecv - r0), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
